// File: rtl/counter_bus_ctrl.sv
// Sequencer for a downstream terminal-count counter that shares one load/count bus.
// Each sequence loads a value, arms the counter, counts its pulses and releases it.
module counter_bus_ctrl #(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [N-1:0]     load_val,
    input  logic [CNT_W-1:0] max_pulses,
    inout  wire  [N-1:0]     out_or_load,
    output logic             we,
    output logic             trig,
    input  logic             out_pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TRIG,
        ST_RUN,
        ST_STOP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [N-1:0]     ld_q, ld_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             we_q, we_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ld_d    = load_val;
                    tgt_d   = max_pulses;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = stop ? ST_STOP : ST_TRIG;
            ST_TRIG: state_d = stop ? ST_STOP : ST_RUN;
            ST_RUN: begin
                if (out_pulse) begin
                    cnt_d = cnt_inc;
                end
                // The target compares against the post-increment count so the
                // sequence ends on the edge that records the final pulse.
                if (stop || ((tgt_q != '0) && (cnt_d == tgt_q))) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered
        // in the same cycle the state they belong to becomes current.
        we_d   = (state_d == ST_RUN);
        trig_d = (state_d == ST_TRIG);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ld_q    <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The bus is released exactly when the counter is told to drive it.
    assign out_or_load = we_q ? {N{1'bz}} : ld_q;

    assign we        = we_q;
    assign trig      = trig_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_counter_bus_ctrl.sv
// Bench for counter_bus_ctrl: two instances (CNT_W=8 and CNT_W=2) each attached to a
// behavioural down-counter that drives the shared bus and out_pulse.
module tb_counter_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, stop, sel;
    logic [2:0] load_val;
    logic [7:0] max_pulses;

    wire  [2:0] bus_a, bus_b;
    logic       we_a, trig_a, busy_a, done_a, op_a;
    logic       we_b, trig_b, busy_b, done_b, op_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       start_a, stop_a, start_b, stop_b;

    int vectors = 0;
    int miscompares = 0;
    int last_lv = 0;
    int last_cnt = 0;

    assign start_a = start & ~sel;
    assign stop_a  = stop & ~sel;
    assign start_b = start & sel;
    assign stop_b  = stop & sel;

    counter_bus_ctrl #(.N(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .load_val(load_val),
        .max_pulses(max_pulses), .out_or_load(bus_a), .we(we_a), .trig(trig_a),
        .out_pulse(op_a), .busy(busy_a), .done(done_a), .pulse_cnt(cnt_a)
    );

    counter_bus_ctrl #(.N(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .load_val(load_val),
        .max_pulses(max_pulses[1:0]), .out_or_load(bus_b), .we(we_b), .trig(trig_b),
        .out_pulse(op_b), .busy(busy_b), .done(done_b), .pulse_cnt(cnt_b)
    );

    // Downstream counter: loads from the bus on trig, counts down while we=1,
    // flags terminal count at zero and reloads; disarmed when bus returns to us.
    logic [2:0] cm_cnt_a, cm_rel_a, cm_cnt_b, cm_rel_b;
    logic       cm_arm_a, cm_arm_b;

    always @(posedge clk) begin
        if (rst) begin
            cm_cnt_a <= 3'd0; cm_rel_a <= 3'd0; cm_arm_a <= 1'b0;
        end else if (trig_a) begin
            cm_cnt_a <= bus_a; cm_rel_a <= bus_a; cm_arm_a <= 1'b1;
        end else if (we_a && cm_arm_a) begin
            cm_cnt_a <= (cm_cnt_a == 3'd0) ? cm_rel_a : cm_cnt_a - 3'd1;
        end else if (!we_a) begin
            cm_arm_a <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            cm_cnt_b <= 3'd0; cm_rel_b <= 3'd0; cm_arm_b <= 1'b0;
        end else if (trig_b) begin
            cm_cnt_b <= bus_b; cm_rel_b <= bus_b; cm_arm_b <= 1'b1;
        end else if (we_b && cm_arm_b) begin
            cm_cnt_b <= (cm_cnt_b == 3'd0) ? cm_rel_b : cm_cnt_b - 3'd1;
        end else if (!we_b) begin
            cm_arm_b <= 1'b0;
        end
    end

    assign op_a  = cm_arm_a && we_a && (cm_cnt_a == 3'd0);
    assign op_b  = cm_arm_b && we_b && (cm_cnt_b == 3'd0);
    assign bus_a = we_a ? cm_cnt_a : 3'bzzz;
    assign bus_b = we_b ? cm_cnt_b : 3'bzzz;

    logic       o_we, o_trig, o_busy, o_done, o_op;
    logic [7:0] o_cnt;
    logic [2:0] o_bus;
    assign o_we   = sel ? we_b   : we_a;
    assign o_trig = sel ? trig_b : trig_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_op   = sel ? op_b   : op_a;
    assign o_cnt  = sel ? {6'b0, cnt_b} : cnt_a;
    assign o_bus  = sel ? bus_b  : bus_a;

    // One full sequence checked against a timeline predicted from the rules:
    // pulse period is lv+1 RUN cycles; RUN ends after mp*(lv+1) cycles or at stop_at.
    task automatic run_seq(input int lv, input int mp, input int stop_at,
                           input bit both, input bit poke);
        int p, sat, lt, len, e_cnt;
        p   = lv + 1;
        sat = sel ? 3 : 255;
        lt  = (mp != 0) ? mp * p : 1 << 30;
        len = (stop_at > 0 && stop_at < lt) ? stop_at : lt;

        @(negedge clk);
        load_val = 3'(lv); max_pulses = 8'(mp); start = 1'b1; stop = both;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        load_val = 3'($urandom); max_pulses = 8'($urandom);
        vectors++;
        if ({o_busy, o_we, o_trig} !== 3'b100 || o_bus !== 3'(lv)) begin
            miscompares++;
            $display("FAIL load_phase busy/we/trig=%b bus=%0d want 100 bus=%0d", {o_busy, o_we, o_trig}, o_bus, lv);
        end
        @(negedge clk);
        vectors++;
        if ({o_busy, o_we, o_trig} !== 3'b101 || o_bus !== 3'(lv)) begin
            miscompares++;
            $display("FAIL trig_phase busy/we/trig=%b bus=%0d want 101 bus=%0d", {o_busy, o_we, o_trig}, o_bus, lv);
        end

        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            e_cnt = ((k - 1) / p > sat) ? sat : (k - 1) / p;
            vectors++;
            if ({o_busy, o_we, o_trig, o_done} !== 4'b1100) begin
                miscompares++;
                $display("FAIL run_phase k=%0d busy/we/trig/done=%b want 1100", k, {o_busy, o_we, o_trig, o_done});
            end
            vectors++;
            if (o_cnt !== 8'(e_cnt)) begin
                miscompares++;
                $display("FAIL run_cnt k=%0d got %0d want %0d", k, o_cnt, e_cnt);
            end
            vectors++;
            if (o_op !== (k % p == 0)) begin
                miscompares++;
                $display("FAIL run_pulse k=%0d got %b want %b", k, o_op, (k % p == 0));
            end
            vectors++;
            if ($isunknown(o_bus) || o_bus !== 3'(lv - ((k - 1) % p))) begin
                miscompares++;
                $display("FAIL run_bus k=%0d got %b want %0d", k, o_bus, lv - ((k - 1) % p));
            end
            if (k == stop_at) stop = 1'b1;
            if (poke && k == 2) start = 1'b1;
        end

        e_cnt = (len / p > sat) ? sat : len / p;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        vectors++;
        if ({o_busy, o_we, o_trig, o_done} !== 4'b1000 || o_cnt !== 8'(e_cnt) || o_bus !== 3'(lv)) begin
            miscompares++;
            $display("FAIL stop_phase bwtd=%b cnt=%0d bus=%0d want 1000 cnt=%0d bus=%0d",
                     {o_busy, o_we, o_trig, o_done}, o_cnt, o_bus, e_cnt, lv);
        end
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b0 || o_done !== 1'b1 || o_cnt !== 8'(e_cnt)) begin
            miscompares++;
            $display("FAIL done_pulse busy=%b done=%b cnt=%0d want 0 1 %0d", o_busy, o_done, o_cnt, e_cnt);
        end
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_cnt !== 8'(e_cnt)) begin
            miscompares++;
            $display("FAIL after_done busy=%b done=%b cnt=%0d want 0 0 %0d", o_busy, o_done, o_cnt, e_cnt);
        end
        last_lv = lv; last_cnt = e_cnt;
        $display("seq dut=%0d lv=%0d mp=%0d stop_at=%0d run=%0d pulse_cnt=%0d", sel, lv, mp, stop_at, len, o_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; sel = 1'b0; load_val = 3'd0; max_pulses = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({we_a, trig_a, busy_a, done_a} !== 4'b0000 || cnt_a !== 8'd0 || bus_a !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_a wtbd=%b cnt=%0d bus=%b want 0000 0 000", {we_a, trig_a, busy_a, done_a}, cnt_a, bus_a);
        end
        vectors++;
        if ({we_b, trig_b, busy_b, done_b} !== 4'b0000 || cnt_b !== 2'd0 || bus_b !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_b wtbd=%b cnt=%0d bus=%b want 0000 0 000", {we_b, trig_b, busy_b, done_b}, cnt_b, bus_b);
        end
        $display("reset checked");
    endtask

    task automatic test_idle_stop();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            vectors++;
            if (o_busy !== 1'b0 || o_done !== 1'b0 || o_cnt !== 8'(last_cnt) || o_bus !== 3'(last_lv)) begin
                miscompares++;
                $display("FAIL idle_stop busy=%b done=%b cnt=%0d bus=%0d want 0 0 %0d %0d",
                         o_busy, o_done, o_cnt, o_bus, last_cnt, last_lv);
            end
        end
        $display("idle stop ignored x3");
    endtask

    task automatic test_stop_early(input bit in_trig);
        int lv;
        lv = $urandom_range(0, 7);
        @(negedge clk);
        load_val = 3'(lv); max_pulses = 8'($urandom_range(1, 5)); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (in_trig) begin
            @(negedge clk);
            vectors++;
            if (o_trig !== 1'b1) begin
                miscompares++;
                $display("FAIL early_trig trig=%b want 1", o_trig);
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        vectors++;
        if ({o_busy, o_we, o_trig, o_done} !== 4'b1000 || o_bus !== 3'(lv)) begin
            miscompares++;
            $display("FAIL early_stop bwtd=%b bus=%0d want 1000 %0d", {o_busy, o_we, o_trig, o_done}, o_bus, lv);
        end
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b0 || o_done !== 1'b1 || o_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL early_done busy=%b done=%b cnt=%0d want 0 1 0", o_busy, o_done, o_cnt);
        end
        last_lv = lv; last_cnt = 0;
        $display("early stop in_trig=%0d lv=%0d", in_trig, lv);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        load_val = 3'd1; max_pulses = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // LOAD -> TRIG -> RUN cycles 1..5; with period 2 the count is 2 in cycle 5
        repeat (6) @(negedge clk);
        vectors++;
        if (o_we !== 1'b1 || o_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL mid_pre we=%b cnt=%0d want 1 2", o_we, o_cnt);
        end
        rst = 1'b1; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        vectors++;
        if ({o_busy, o_we, o_trig, o_done} !== 4'b0000 || o_cnt !== 8'd0 || o_bus !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_reset bwtd=%b cnt=%0d bus=%b want 0000 0 000", {o_busy, o_we, o_trig, o_done}, o_cnt, o_bus);
        end
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_after busy=%b done=%b want 0 0", o_busy, o_done);
        end
        $display("reset during run checked");
    endtask

    task automatic test_random();
        int lv, mp, sa;
        for (int i = 0; i < 8; i++) begin
            lv = $urandom_range(0, 7);
            mp = $urandom_range(0, 6);
            if (mp == 0) sa = $urandom_range(1, 30);
            else sa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, mp * (lv + 1)) : 0;
            run_seq(lv, mp, sa, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        run_seq(5, 3, 0, 1'b0, 1'b0);      // main target-terminated sequence
        run_seq(2, 0, 20, 1'b0, 1'b0);     // free run stopped after 20 RUN cycles
        test_idle_stop();
        run_seq(3, 2, 0, 1'b0, 1'b1);      // start during RUN is ignored
        run_seq(1, 2, 0, 1'b1, 1'b0);      // start and stop together in IDLE
        test_stop_early(1'b0);
        test_stop_early(1'b1);
        test_random();
        test_reset_mid();
        sel = 1'b1;
        run_seq(0, 0, 10, 1'b0, 1'b0);     // CNT_W=2 saturation with load 0
        sel = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_bus_ctrl.md
COUNTER_BUS_CTRL -- requirements
Module: counter_bus_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the width of the shared load/count bus.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the pulse counter and the pulse target.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: command pulse that begins a load/run sequence.
REQ-006 The block SHALL have port stop, input, 1 bit: command pulse that aborts or ends the current sequence.
REQ-007 The block SHALL have port load_val, input, N bits: terminal value, captured when start is accepted.
REQ-008 The block SHALL have port max_pulses, input, CNT_W bits: pulse target, captured when start is accepted; 0 means run until stop.
REQ-009 The block SHALL have port out_or_load, inout, N bits: shared bus to the downstream counter.
REQ-010 The block SHALL have port we, output, 1 bit: 1 = counter drives the bus and counts; 0 = this block drives the bus.
REQ-011 The block SHALL have port trig, output, 1 bit: arm strobe to the counter.
REQ-012 The block SHALL have port out_pulse, input, 1 bit: terminal-count indication from the counter.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse on return to IDLE.
REQ-015 The block SHALL have port pulse_cnt, output, CNT_W bits: pulses counted in the current or last sequence.

Function
REQ-016 The block SHALL drive out_or_load with the captured value ld_r whenever we=0, and SHALL hold the bus at high-Z whenever we=1, so the bus has exactly one driver in every cycle.
REQ-017 The FSM SHALL have the states IDLE, LOAD, TRIG, RUN and STOP, with all outputs registered.
REQ-018 In IDLE, start=1 SHALL capture ld_r<=load_val and tgt<=max_pulses, clear pulse_cnt to 0, and move to LOAD.
REQ-019 LOAD SHALL last 1 cycle with we=0 and trig=0 (the load value settles on the bus), then move to TRIG.
REQ-020 TRIG SHALL last 1 cycle with we=0 and trig=1 (the bus is still driven, giving a rising trig edge), then move to RUN.
REQ-021 RUN SHALL hold we=1 and trig=0, and SHALL increment pulse_cnt in every cycle where out_pulse=1, saturating at 2^CNT_W-1.
REQ-022 RUN SHALL move to STOP when stop=1, or when tgt!=0 and the next value of pulse_cnt equals tgt.
REQ-023 STOP SHALL last 1 cycle with we=0 and trig=0 (this clears the counter's armed state), then move to IDLE with done=1 for that one cycle.
REQ-024 stop=1 in LOAD or TRIG SHALL go to STOP on the next edge.
REQ-025 stop=1 in IDLE SHALL be ignored.
REQ-026 start=1 in any state other than IDLE SHALL be ignored.
REQ-027 If start and stop are both 1 in IDLE, start SHALL take effect.
REQ-028 out_pulse SHALL be ignored outside RUN.
REQ-029 pulse_cnt SHALL hold its value after the sequence ends, until the next accepted start.
REQ-030 load_val=0 SHALL be legal; the counter then asserts out_pulse continuously and pulse_cnt increments every RUN cycle.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL enter IDLE and set we=0, trig=0, busy=0, done=0, pulse_cnt=0, ld_r=0 and tgt=0; out_or_load SHALL then be driven to 0.
REQ-032 Reset asserted mid-sequence (including in RUN) SHALL take priority over start and stop and SHALL NOT produce a done pulse.

Verification
REQ-033 The bench SHALL apply rst for 2 cycles, and SHALL check that we=0, trig=0, busy=0 and pulse_cnt=0, and that the bus reads 3'b000.
REQ-034 With N=3, the bench SHALL apply start with load_val=5 and max_pulses=3, and SHALL check that the sequence goes LOAD, TRIG, RUN; that out_pulse occurs every 6 cycles in RUN; and that 3 pulses give pulse_cnt=3 followed by STOP, then a done pulse with busy=0.
REQ-035 The bench SHALL apply start with max_pulses=0 and load_val=2, then stop after 20 RUN cycles, and SHALL check that pulse_cnt=6 or 7 (counted consistently with the counter model), that STOP lasts 1 cycle with we=0, and that done=1 once.
REQ-036 The bench SHALL apply start during RUN, and stop while in IDLE, and SHALL check that no state change occurs in either case.
REQ-037 The bench SHALL apply rst while in RUN with pulse_cnt=2, and SHALL check that the next cycle is IDLE with we=0, pulse_cnt=0, done=0, and the bus driven to 0.
REQ-038 The bench SHALL run with CNT_W=2, load_val=0 and max_pulses=0, and SHALL check that pulse_cnt saturates at 3 and the bus is never double-driven (never X).
